// File: rtl/decode_execute_register.sv
// Decode→Execute pipeline register with load-use hazard bubble, external stall and branch flush.
// Optional event counters (bubble/flush/ext-stall) are built when DECODE_EXECUTE_PERF_EN is defined.
module decode_execute_register #(
    parameter int unsigned WIDTH        = 24,
    parameter int unsigned VECTOR_WIDTH = 8,
    parameter int unsigned ADDRESSWIDTH = 4,
    parameter int unsigned OPCODEWIDTH  = 4,
    parameter logic [OPCODEWIDTH-1:0] LOAD_OPCODE = OPCODEWIDTH'(5)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            valid_D,
    input  logic                            stall_ext,
    input  logic                            flush,
    input  logic [OPCODEWIDTH-1:0]          opcode_D,
    input  logic [ADDRESSWIDTH-1:0]         regDestinationAddress_D,
    input  logic [ADDRESSWIDTH-1:0]         reg1Address_D,
    input  logic [ADDRESSWIDTH-1:0]         reg2Address_D,
    input  logic [WIDTH-1:0]                reg1Content_D,
    input  logic [WIDTH-1:0]                reg2Content_D,
    input  logic [WIDTH-1:0]                inmediate_D,
    input  logic [WIDTH-1:0]                PC_D,
    input  logic [VECTOR_WIDTH*WIDTH-1:0]   data_out_D,
    input  logic [VECTOR_WIDTH*WIDTH-1:0]   data_out2_D,
    input  logic                            isvector_D,
    input  logic                            vect_esc_D,
    input  logic [2:0]                      index_D,
    output logic                            valid_E,
    output logic [OPCODEWIDTH-1:0]          opcode_E,
    output logic [ADDRESSWIDTH-1:0]         regDestinationAddress_E,
    output logic [ADDRESSWIDTH-1:0]         reg1Address_E,
    output logic [ADDRESSWIDTH-1:0]         reg2Address_E,
    output logic [WIDTH-1:0]                reg1Content_E,
    output logic [WIDTH-1:0]                reg2Content_E,
    output logic [WIDTH-1:0]                inmediate_E,
    output logic [WIDTH-1:0]                PC_E,
    output logic [VECTOR_WIDTH*WIDTH-1:0]   data_out_E,
    output logic [VECTOR_WIDTH*WIDTH-1:0]   data_out2_E,
    output logic                            isvector_E,
    output logic                            vect_esc_E,
    output logic [2:0]                      index_E,
    output logic                            stall_D,
    output logic                            hazard_E
`ifdef DECODE_EXECUTE_PERF_EN
    ,
    output logic [15:0]                     bubble_count,
    output logic [15:0]                     flush_count,
    output logic [15:0]                     ext_stall_count
`endif
);

    logic clear_e;
    logic load_e;

    // Conservative load-use check: vector/scalar flags are deliberately ignored.
    assign hazard_E = valid_D & valid_E & (opcode_E == LOAD_OPCODE) &
                      ((reg1Address_D == regDestinationAddress_E) |
                       (reg2Address_D == regDestinationAddress_E));

    // Gated by reset so Fetch/Decode never see a stall while the pipe is being cleared.
    assign stall_D = reset & (stall_ext | (hazard_E & ~flush));

    // Flush beats the external stall; a hazard only bubbles when Execute is free to advance.
    assign clear_e = flush | (~stall_ext & hazard_E);
    assign load_e  = ~stall_ext;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_E                 <= 1'b0;
            opcode_E                <= '0;
            regDestinationAddress_E <= '0;
            reg1Address_E           <= '0;
            reg2Address_E           <= '0;
            reg1Content_E           <= '0;
            reg2Content_E           <= '0;
            inmediate_E             <= '0;
            PC_E                    <= '0;
            data_out_E              <= '0;
            data_out2_E             <= '0;
            isvector_E              <= 1'b0;
            vect_esc_E              <= 1'b0;
            index_E                 <= '0;
        end else if (clear_e) begin
            valid_E                 <= 1'b0;
            opcode_E                <= '0;
            regDestinationAddress_E <= '0;
            reg1Address_E           <= '0;
            reg2Address_E           <= '0;
            reg1Content_E           <= '0;
            reg2Content_E           <= '0;
            inmediate_E             <= '0;
            PC_E                    <= '0;
            data_out_E              <= '0;
            data_out2_E             <= '0;
            isvector_E              <= 1'b0;
            vect_esc_E              <= 1'b0;
            index_E                 <= '0;
        end else if (load_e) begin
            valid_E                 <= valid_D;
            opcode_E                <= opcode_D;
            regDestinationAddress_E <= regDestinationAddress_D;
            reg1Address_E           <= reg1Address_D;
            reg2Address_E           <= reg2Address_D;
            reg1Content_E           <= reg1Content_D;
            reg2Content_E           <= reg2Content_D;
            inmediate_E             <= inmediate_D;
            PC_E                    <= PC_D;
            data_out_E              <= data_out_D;
            data_out2_E             <= data_out2_D;
            isvector_E              <= isvector_D;
            vect_esc_E              <= vect_esc_D;
            index_E                 <= index_D;
        end
    end

`ifdef DECODE_EXECUTE_PERF_EN
    logic bubble_ev;
    logic ext_stall_ev;

    assign bubble_ev    = ~flush & ~stall_ext & hazard_E;
    assign ext_stall_ev = stall_ext & ~flush;

    // Saturating event counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bubble_count    <= '0;
            flush_count     <= '0;
            ext_stall_count <= '0;
        end else begin
            if (bubble_ev && (bubble_count != 16'hFFFF))
                bubble_count <= bubble_count + 16'd1;
            if (flush && (flush_count != 16'hFFFF))
                flush_count <= flush_count + 16'd1;
            if (ext_stall_ev && (ext_stall_count != 16'hFFFF))
                ext_stall_count <= ext_stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/decode_execute_register.md
Name: decode_execute_register

Overview:
- Pipeline register between the Decode stage and the Execute stage of the scalar/vector processor.
- Captures every Decode output each cycle:
  - opcode, addresses, immediate and PC
  - scalar operands and vector operands
  - vector flags and lane index
- Adds a valid bit and honours a downstream stall and a branch flush.
- Detects load-use RAW hazards against the instruction held in Execute, inserting a one-cycle bubble and stalling Fetch/Decode.

Parameters:
WIDTH, 24, scalar data / lane width
VECTOR_WIDTH, 8, lanes per vector register
ADDRESSWIDTH, 4, register address width
OPCODEWIDTH, 4, opcode width
LOAD_OPCODE, 4'b0101, opcode value of scalar/vector load instructions

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (reset==0 clears all state)
valid_D  input  1  Decode holds a real instruction
stall_ext  input  1  downstream (memory) busy; hold Execute contents
flush  input  1  branch taken; kill instruction entering Execute
opcode_D  input  OPCODEWIDTH  decoded opcode
regDestinationAddress_D  input  ADDRESSWIDTH  destination register
reg1Address_D  input  ADDRESSWIDTH  source register 1
reg2Address_D  input  ADDRESSWIDTH  source register 2
reg1Content_D  input  WIDTH  operand 1
reg2Content_D  input  WIDTH  operand 2
inmediate_D  input  WIDTH  zero-extended immediate
PC_D  input  WIDTH  instruction PC
data_out_D  input  VECTOR_WIDTH*WIDTH  vector operand 1
data_out2_D  input  VECTOR_WIDTH*WIDTH  vector operand 2
isvector_D  input  1  vector instruction flag
vect_esc_D  input  1  vector-scalar flag
index_D  input  3  lane index
valid_E  output  1  Execute register holds a real instruction
(all _D data fields mirrored as _E outputs, same widths)
stall_D  output  1  hold PC and Decode inputs this cycle
hazard_E  output  1  load-use hazard detected this cycle (combinational)

Behaviour:
- Reset (reset==0, asynchronous): valid_E=0 and every _E field = 0. Counters cleared if the optional feature is present. stall_D and hazard_E are 0 while in reset.
- hazard_E (combinational) = valid_D & valid_E & (opcode_E==LOAD_OPCODE) & ((reg1Address_D==regDestinationAddress_E) | (reg2Address_D==regDestinationAddress_E)).
  - The comparison is conservative: it ignores the isvector and vect_esc flags.
- stall_D = stall_ext | (hazard_E & ~flush).
- Next-state priority at each rising clock edge, highest first:
  1. flush: valid_E<=0 and all _E fields<=0. This applies even when stall_ext=1.
  2. stall_ext: all _E registers hold, including valid_E.
  3. hazard_E: bubble. valid_E<=0 and _E fields<=0. Decode is held by stall_D.
  4. Otherwise: all _E fields <= _D fields, and valid_E<=valid_D.
     - If valid_D==0, the _D data fields are still captured but valid_E=0.
- Latency: one cycle from _D inputs to _E outputs.
- A load-use hazard costs exactly one bubble. After the bubble, valid_E=0, so hazard_E drops and the held instruction advances on the next edge.
- Back-to-back loads to the same register produce one bubble per dependent instruction.
- Vector buses (data_out_D, data_out2_D) are registered as VECTOR_WIDTH lanes. Lane i is at bits [i*WIDTH +: WIDTH]. There is no per-lane gating.
- Reset asserted mid-stall: the stall is abandoned and everything is cleared immediately. After reset deasserts, the first edge performs a normal load.

Optional Feature:
- Macro: DECODE_EXECUTE_PERF_EN.
- When defined, adds three outputs:
  - bubble_count: 16-bit
  - flush_count: 16-bit
  - ext_stall_count: 16-bit
- Increment rules, each on a clock edge, each counter saturating at 16'hFFFF:
  - bubble_count: a hazard bubble is inserted.
  - flush_count: flush==1.
  - ext_stall_count: stall_ext==1 and flush==0.
- All three counters clear on reset.
- When the macro is undefined, the ports and counters do not exist. Remaining behaviour is identical.

Test Plan:
- Normal flow: load valid_D=1, opcode_D=4'h1, reg1Content_D=24'h00ABCD, data_out_D lane3=24'h123456. After 1 edge: valid_E=1, reg1Content_E=24'h00ABCD, data_out_E lane3=24'h123456. stall_D=0.
- Load-use: cycle 0 sends opcode_D=LOAD_OPCODE, regDestinationAddress_D=4'd3. Cycle 1 sends an instruction with reg2Address_D=4'd3.
  - Required: hazard_E=1 and stall_D=1 in cycle 1.
  - Next edge gives valid_E=0 (bubble). The following edge gives the dependent instruction in Execute with valid_E=1.
  - bubble_count=1 when the optional feature is enabled.
- External stall: assert stall_ext for 3 cycles while Execute holds PC_E=24'h000010. Required: PC_E stays 24'h000010 and stall_D=1 for all 3 cycles. The Decode instruction enters on the first edge after release.
- Flush priority: assert flush together with stall_ext and a pending hazard. Required: valid_E=0 and all _E fields = 0 after the edge. stall_D=1 because stall_ext=1. hazard_E has no effect on the next state.
- Async reset mid-operation: drop reset between clock edges while valid_E=1. Required: valid_E=0 and all _E fields = 0 immediately, with no clock edge. Counters read 0.
- No false hazard: load to reg 4 in Execute, with Decode sources 1 and 2. Required: hazard_E=0 and no bubble.
